// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and the writeback pipeline register layout.
// Imported by the writeback stage and its forwarding muxes.
package cpu_pkg;

   localparam int DATA_W   = 64;
   localparam int ZERO_REG = 31;

   typedef struct packed {
      logic              valid;
      logic              we;
      logic [4:0]        rd;
      logic [DATA_W-1:0] data;
      logic              committed;
   } wb_reg_t;

endpackage

// File: rtl/fwd_mux.sv
// Decode operand select: zero register, else WB-stage bypass, else regfile data.
// Purely combinational, no backpressure; forwards a held entry regardless of commit state.
module fwd_mux #(
   parameter int DATA_W   = cpu_pkg::DATA_W,
   parameter int ZERO_REG = cpu_pkg::ZERO_REG
) (
   input  logic [4:0]        i_rd_idx,
   input  logic [DATA_W-1:0] i_reg_data,
   input  logic              i_wb_valid,
   input  logic              i_wb_we,
   input  logic [4:0]        i_wb_rd,
   input  logic [DATA_W-1:0] i_wb_data,
   output logic [DATA_W-1:0] o_operand
);

   always_comb begin
      o_operand = i_reg_data;
      if (i_rd_idx == 5'(ZERO_REG)) begin
         o_operand = '0;
      end else if (i_wb_valid && i_wb_we && (i_wb_rd == i_rd_idx)) begin
         o_operand = i_wb_data;
      end
   end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: one pipeline register feeding the regfile write port plus operand forwarding.
// Latency one cycle MEM->regfile; stall holds the entry and commits its write only once.
module writeback_stage
   import cpu_pkg::*;
#(
   parameter int DATA_W   = cpu_pkg::DATA_W,
   parameter int ZERO_REG = cpu_pkg::ZERO_REG
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_valid,
   input  logic              mem_RegWrite,
   input  logic              mem_MemToReg,
   input  logic [4:0]        mem_Rd,
   input  logic [DATA_W-1:0] mem_ALUResult,
   input  logic [DATA_W-1:0] mem_ReadData,
   input  logic              stall,
   input  logic              flush,
   input  logic [4:0]        ReadRegister1,
   input  logic [4:0]        ReadRegister2,
   input  logic [DATA_W-1:0] RegData1,
   input  logic [DATA_W-1:0] RegData2,
   output logic              RegWrite,
   output logic [4:0]        WriteRegister,
   output logic [DATA_W-1:0] WriteData,
   output logic [DATA_W-1:0] Operand1,
   output logic [DATA_W-1:0] Operand2,
   output logic [31:0]       retired
);

   wb_reg_t           r_wb;
   logic [31:0]       r_retired;
   logic [DATA_W-1:0] w_result;
   logic              w_regwrite;

   assign w_result = mem_MemToReg ? mem_ReadData : mem_ALUResult;

   // committed marks a held entry whose write already reached the regfile
   assign w_regwrite = r_wb.valid & r_wb.we & (r_wb.rd != 5'(ZERO_REG)) & ~r_wb.committed;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wb      <= '0;
         r_retired <= '0;
      end else begin
         if (!stall) begin
            r_wb.valid     <= mem_valid & ~flush;
            r_wb.we        <= mem_RegWrite;
            r_wb.rd        <= mem_Rd;
            r_wb.data      <= w_result;
            r_wb.committed <= 1'b0;
         end else if (w_regwrite) begin
            r_wb.committed <= 1'b1;
         end
         if (w_regwrite) begin
            r_retired <= r_retired + 32'd1;
         end
      end
   end

   assign RegWrite      = w_regwrite;
   assign WriteRegister = r_wb.rd;
   assign WriteData     = r_wb.data;
   assign retired       = r_retired;

   fwd_mux #(.DATA_W(DATA_W), .ZERO_REG(ZERO_REG)) u_fwd1 (
      .i_rd_idx   (ReadRegister1),
      .i_reg_data (RegData1),
      .i_wb_valid (r_wb.valid),
      .i_wb_we    (r_wb.we),
      .i_wb_rd    (r_wb.rd),
      .i_wb_data  (r_wb.data),
      .o_operand  (Operand1)
   );

   fwd_mux #(.DATA_W(DATA_W), .ZERO_REG(ZERO_REG)) u_fwd2 (
      .i_rd_idx   (ReadRegister2),
      .i_reg_data (RegData2),
      .i_wb_valid (r_wb.valid),
      .i_wb_we    (r_wb.we),
      .i_wb_rd    (r_wb.rd),
      .i_wb_data  (r_wb.data),
      .o_operand  (Operand2)
   );

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: write scoreboard plus a small model of the WB entry for forwarding.
// Inputs change after the sample point; outputs are sampled 1 time unit after each rising edge.
module tb_writeback_stage;

   logic        clk;
   logic        reset;
   logic        mem_valid, mem_RegWrite, mem_MemToReg;
   logic [4:0]  mem_Rd;
   logic [63:0] mem_ALUResult, mem_ReadData;
   logic        stall, flush;
   logic [4:0]  ReadRegister1, ReadRegister2;
   logic [63:0] RegData1, RegData2;
   logic        RegWrite;
   logic [4:0]  WriteRegister;
   logic [63:0] WriteData, Operand1, Operand2;
   logic [31:0] retired;

   typedef struct packed {
      logic [4:0]  rd;
      logic [63:0] data;
   } wr_t;

   wr_t         sbq[$];
   int          n_chk = 0;
   int          n_bad = 0;
   logic [31:0] m_ret;
   logic        m_valid, m_we;
   logic [4:0]  m_rd;
   logic [63:0] m_data;

   writeback_stage dut (
      .clk           (clk),
      .reset         (reset),
      .mem_valid     (mem_valid),
      .mem_RegWrite  (mem_RegWrite),
      .mem_MemToReg  (mem_MemToReg),
      .mem_Rd        (mem_Rd),
      .mem_ALUResult (mem_ALUResult),
      .mem_ReadData  (mem_ReadData),
      .stall         (stall),
      .flush         (flush),
      .ReadRegister1 (ReadRegister1),
      .ReadRegister2 (ReadRegister2),
      .RegData1      (RegData1),
      .RegData2      (RegData2),
      .RegWrite      (RegWrite),
      .WriteRegister (WriteRegister),
      .WriteData     (WriteData),
      .Operand1      (Operand1),
      .Operand2      (Operand2),
      .retired       (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] exp_operand(input logic [4:0] idx, input logic [63:0] regdata);
      if (idx == 5'd31) return 64'd0;
      if (m_valid && m_we && (m_rd == idx)) return m_data;
      return regdata;
   endfunction

   task automatic drive(input logic v, input logic we, input logic m2r, input logic [4:0] rd,
                        input logic [63:0] alu, input logic [63:0] ld, input logic st, input logic fl);
      mem_valid     = v;
      mem_RegWrite  = we;
      mem_MemToReg  = m2r;
      mem_Rd        = rd;
      mem_ALUResult = alu;
      mem_ReadData  = ld;
      stall         = st;
      flush         = fl;
   endtask

   task automatic reads(input logic [4:0] r1, input logic [63:0] d1, input logic [4:0] r2, input logic [63:0] d2);
      ReadRegister1 = r1;
      RegData1      = d1;
      ReadRegister2 = r2;
      RegData2      = d2;
   endtask

   // One clock: predict from the driven inputs, then compare outputs after the edge.
   task automatic cycle();
      wr_t w;
      if (!reset && !stall && mem_valid && !flush && mem_RegWrite && mem_Rd != 5'd31) begin
         w.rd   = mem_Rd;
         w.data = mem_MemToReg ? mem_ReadData : mem_ALUResult;
         sbq.push_back(w);
      end
      @(posedge clk);
      #1;
      if (reset) begin
         sbq.delete();
         m_ret   = 32'd0;
         m_valid = 1'b0;
         m_we    = 1'b0;
         m_rd    = 5'd0;
         m_data  = 64'd0;
      end else if (!stall) begin
         m_valid = mem_valid & ~flush;
         m_we    = mem_RegWrite;
         m_rd    = mem_Rd;
         m_data  = mem_MemToReg ? mem_ReadData : mem_ALUResult;
      end
      check_eq("retired", 64'(retired), 64'(m_ret));
      if (sbq.size() > 0) begin
         w = sbq.pop_front();
         check_eq("regwrite_hi", 64'(RegWrite), 64'd1);
         check_eq("wr_reg", 64'(WriteRegister), 64'(w.rd));
         check_eq("wr_data", WriteData, w.data);
         m_ret = m_ret + 32'd1;
      end else begin
         check_eq("regwrite_lo", 64'(RegWrite), 64'd0);
      end
      check_eq("operand1", Operand1, exp_operand(ReadRegister1, RegData1));
      check_eq("operand2", Operand2, exp_operand(ReadRegister2, RegData2));
   endtask

   initial begin
      m_ret = 32'd0; m_valid = 1'b0; m_we = 1'b0; m_rd = 5'd0; m_data = 64'd0;
      drive(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 1'b0, 1'b0);
      reads(5'd31, 64'h55, 5'd2, 64'h1234);
      reset = 1'b1;
      cycle();
      cycle();
      check_eq("rst_wreg", 64'(WriteRegister), 64'd0);
      check_eq("rst_wdata", WriteData, 64'd0);
      check_eq("rst_op1_zero", Operand1, 64'd0);
      check_eq("rst_op2_pass", Operand2, 64'h1234);
      reset = 1'b0;

      // write to the zero register is suppressed and never forwarded
      drive(1'b1, 1'b1, 1'b0, 5'd31, 64'hA0, 64'd0, 1'b0, 1'b0);
      cycle();
      drive(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 1'b0, 1'b0);
      cycle();
      check_eq("zero_reg_ret", 64'(retired), 64'd0);

      // ALU write to x5, forwarded on port 1 only
      drive(1'b1, 1'b1, 1'b0, 5'd5, 64'h0000010204080001, 64'hFFFF, 1'b0, 1'b0);
      reads(5'd5, 64'd0, 5'd4, 64'hCAFE);
      cycle();
      check_eq("fwd_x5", Operand1, 64'h0000010204080001);
      check_eq("nofwd_x4", Operand2, 64'hCAFE);
      drive(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 1'b0, 1'b0);
      cycle();
      check_eq("ret_after_x5", 64'(retired), 64'd1);

      // load to x7 held by a 3-cycle stall: one commit, forwarding throughout
      drive(1'b1, 1'b1, 1'b1, 5'd7, 64'h1111, 64'hDEAD, 1'b0, 1'b0);
      reads(5'd7, 64'd0, 5'd9, 64'h99);
      cycle();
      drive(1'b1, 1'b1, 1'b0, 5'd9, 64'h2222, 64'd0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle();
         check_eq("stall_fwd_x7", Operand1, 64'hDEAD);
      end
      drive(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 1'b0, 1'b0);
      cycle();
      check_eq("ret_after_stall", 64'(retired), 64'd2);

      // flushed instruction never writes
      drive(1'b1, 1'b1, 1'b0, 5'd3, 64'h3333, 64'd0, 1'b0, 1'b1);
      reads(5'd3, 64'h77, 5'd10, 64'h88);
      cycle();
      cycle();
      check_eq("flush_ret", 64'(retired), 64'd2);

      // flush under stall leaves the held entry intact
      drive(1'b1, 1'b1, 1'b0, 5'd10, 64'hAAAA, 64'd0, 1'b0, 1'b0);
      cycle();
      drive(1'b1, 1'b1, 1'b0, 5'd11, 64'hBBBB, 64'd0, 1'b1, 1'b1);
      cycle();
      check_eq("stall_flush_fwd", Operand2, 64'hAAAA);
      cycle();

      // randomized traffic
      for (int i = 0; i < 60; i++) begin
         drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), 1'($urandom),
               5'($urandom_range(26, 31)), {$urandom, $urandom}, {$urandom, $urandom},
               1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0));
         reads(5'($urandom_range(26, 31)), {$urandom, $urandom}, 5'($urandom_range(26, 31)), {$urandom, $urandom});
         cycle();
      end
      drive(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 1'b0, 1'b0);
      cycle();

      // reset while a write is pending drops it
      drive(1'b1, 1'b1, 1'b0, 5'd12, 64'hC0C0, 64'd0, 1'b0, 1'b0);
      cycle();
      drive(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 1'b0, 1'b0);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      check_eq("rst_pending_ret", 64'(retired), 64'd0);
      check_eq("rst_pending_we", 64'(RegWrite), 64'd0);
      cycle();

      // counter wrap: preload the counter to all ones, then commit once
      dut.r_retired = 32'hFFFF_FFFF;
      m_ret = 32'hFFFF_FFFF;
      drive(1'b1, 1'b1, 1'b0, 5'd13, 64'hD0D0, 64'd0, 1'b0, 1'b0);
      cycle();
      drive(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 1'b0, 1'b0);
      cycle();
      check_eq("wrap_ret", 64'(retired), 64'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
